dmem_bridge: RTL

DMEM_BRIDGE -- requirements
Module: dmem_bridge

---
 rtl/cpu_pkg.sv | 16 +
 rtl/dmem_bridge.sv | 103 ++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-bridge FSM encoding and access size codes,
// common to the data-side bridge and the instruction-side bridge.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bridge_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/dmem_bridge.sv
// Memory-stage to SRAM-like bus bridge: one outstanding access, pipeline
// stalled from the first mem_en cycle until the DONE cycle.
module dmem_bridge
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [1:0]        dbg_state
);

  // Handshake: data_req is held from the ADDR entry edge until the edge on
  // which data_addr_ok=1 is seen; data_data_ok counts only after (or in the
  // same cycle as) that acceptance, one completion per request.

  bridge_state_e     state_q;
  logic              req_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_en) begin
            state_q <= ADDR;
            req_q   <= 1'b1;
            wr_q    <= |mem_wen;
            size_q  <= mem_size;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wen;
          end
        end
        ADDR: begin
          if (data_addr_ok) begin
            req_q <= 1'b0;
            if (data_data_ok) begin
              state_q <= DONE;
              if (!wr_q) rdata_q <= data_rdata;
            end else begin
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (data_data_ok) begin
            state_q <= DONE;
            if (!wr_q) rdata_q <= data_rdata;
          end
        end
        DONE: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  // Releasing the stall in DONE is what lets the pipeline advance.
  assign mem_stall  = mem_en && (state_q != DONE);
  assign mem_rdata  = rdata_q;
  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign data_wstrb = wstrb_q;
  assign dbg_state  = state_q;

endmodule
